// File: rtl/wb_bridge_nway.sv
// N-way Wishbone classic bridge: decodes the upstream slave bus into NUM_PORTS windows,
// terminates unmapped accesses and times out silent downstream ports with sticky error flags.
module wb_bridge_nway #(
   parameter int          NUM_PORTS      = 4,
   parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
   parameter int          WINDOW_BITS    = 20,
   parameter int          DS_ADDR_WIDTH  = 20,
   parameter int          TIMEOUT_CYCLES = 16,
   parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
   input  logic                        wb_clk_i,
   input  logic                        wb_rst_i,
   input  logic                        wbs_stb_i,
   input  logic                        wbs_cyc_i,
   input  logic                        wbs_we_i,
   input  logic [3:0]                  wbs_sel_i,
   input  logic [31:0]                 wbs_dat_i,
   input  logic [31:0]                 wbs_adr_i,
   output logic                        wbs_ack_o,
   output logic [31:0]                 wbs_dat_o,
   output logic [NUM_PORTS-1:0]        wbm_stb_o,
   output logic [NUM_PORTS-1:0]        wbm_cyc_o,
   output logic                        wbm_we_o,
   output logic [3:0]                  wbm_sel_o,
   output logic [DS_ADDR_WIDTH-1:0]    wbm_adr_o,
   output logic [31:0]                 wbm_dat_o,
   input  logic [NUM_PORTS-1:0]        wbm_ack_i,
   input  logic [32*NUM_PORTS-1:0]     wbm_dat_i,
   input  logic                        err_clr_i,
   output logic [1:0]                  err_flags_o
);

   localparam int SEL_BITS = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1;
   localparam int DEC_LSB  = WINDOW_BITS + SEL_BITS;
   localparam int CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACTIVE = 2'd1;
   localparam logic [1:0] RESP   = 2'd2;

   logic [1:0]           state;
   logic [SEL_BITS-1:0]  req_idx;
   logic [SEL_BITS-1:0]  cur_idx;
   logic                 req_mapped;
   logic                 req_take;
   logic [NUM_PORTS-1:0] req_onehot;
   logic [CNT_W-1:0]     tmo_cnt;
   logic                 tmo_hit;
   logic [31:0]          rsp_data;
   logic                 sel_ack;
   logic [31:0]          sel_dat;
   logic [1:0]           err_set;

   assign req_idx    = wbs_adr_i[WINDOW_BITS +: SEL_BITS];
   assign req_mapped = (wbs_adr_i[31:DEC_LSB] == BASE_ADDR[31:DEC_LSB]) &&
                       (int'(req_idx) < NUM_PORTS);
   // While the upstream ack is still showing, the host has not yet dropped its strobe.
   assign req_take   = wbs_stb_i && wbs_cyc_i && !wbs_ack_o;
   assign tmo_hit    = (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      req_onehot = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         req_onehot[i] = (int'(req_idx) == i);
      end
   end

   always_comb begin
      sel_ack = 1'b0;
      sel_dat = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (int'(cur_idx) == i) begin
            sel_ack = wbm_ack_i[i];
            sel_dat = wbm_dat_i[32*i +: 32];
         end
      end
   end

   // Abort takes priority, then a downstream ack beats a simultaneous timeout.
   always_comb begin
      err_set = 2'b00;
      if (state == IDLE && req_take && !req_mapped) begin
         err_set[0] = 1'b1;
      end
      if (state == ACTIVE && wbs_cyc_i && !sel_ack && tmo_hit) begin
         err_set[1] = 1'b1;
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state       <= IDLE;
         cur_idx     <= '0;
         tmo_cnt     <= '0;
         rsp_data    <= '0;
         wbs_ack_o   <= 1'b0;
         wbs_dat_o   <= '0;
         wbm_stb_o   <= '0;
         wbm_cyc_o   <= '0;
         wbm_we_o    <= 1'b0;
         wbm_sel_o   <= '0;
         wbm_adr_o   <= '0;
         wbm_dat_o   <= '0;
         err_flags_o <= 2'b00;
      end else begin
         wbs_ack_o   <= 1'b0;
         err_flags_o <= (err_flags_o & {2{~err_clr_i}}) | err_set;
         case (state)
            IDLE: begin
               if (req_take) begin
                  wbm_we_o  <= wbs_we_i;
                  wbm_sel_o <= wbs_sel_i;
                  wbm_adr_o <= wbs_adr_i[DS_ADDR_WIDTH-1:0];
                  wbm_dat_o <= wbs_dat_i;
                  cur_idx   <= req_idx;
                  tmo_cnt   <= '0;
                  if (req_mapped) begin
                     wbm_stb_o <= req_onehot;
                     wbm_cyc_o <= req_onehot;
                     state     <= ACTIVE;
                  end else begin
                     rsp_data  <= ERR_DATA;
                     state     <= RESP;
                  end
               end
            end
            ACTIVE: begin
               if (!wbs_cyc_i) begin
                  wbm_stb_o <= '0;
                  wbm_cyc_o <= '0;
                  state     <= IDLE;
               end else if (sel_ack) begin
                  rsp_data  <= sel_dat;
                  wbm_stb_o <= '0;
                  wbm_cyc_o <= '0;
                  state     <= RESP;
               end else if (tmo_hit) begin
                  rsp_data  <= ERR_DATA;
                  wbm_stb_o <= '0;
                  wbm_cyc_o <= '0;
                  state     <= RESP;
               end else begin
                  tmo_cnt   <= tmo_cnt + 1'b1;
               end
            end
            RESP: begin
               wbs_ack_o <= 1'b1;
               wbs_dat_o <= rsp_data;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_bridge_nway.sv
// Bench for wb_bridge_nway: directed cases plus randomized accesses scored against
// a transaction-level model of decode, latency, response data and sticky flags.
module tb_wb_bridge_nway;

   localparam int          NP   = 4;
   localparam int          T    = 16;
   localparam logic [31:0] BASE = 32'h3000_0000;
   localparam logic [31:0] ERR  = 32'hDEAD_BEEF;
   localparam int          NEVER = 1000;

   logic           clk = 1'b0;
   logic           rst;
   logic           stb, cyc, we, err_clr;
   logic [3:0]     sel;
   logic [31:0]    wdat, adr;
   logic           wbs_ack;
   logic [31:0]    wbs_dat;
   logic [NP-1:0]  wbm_stb, wbm_cyc, wbm_ack;
   logic           wbm_we;
   logic [3:0]     wbm_sel;
   logic [19:0]    wbm_adr;
   logic [31:0]    wbm_dat;
   logic [32*NP-1:0] wbm_rdat;
   logic [1:0]     err_flags;

   logic           d3_ack;
   logic [31:0]    d3_dat;
   logic [2:0]     d3_stb, d3_cyc;
   logic           d3_we;
   logic [3:0]     d3_sel;
   logic [19:0]    d3_adr;
   logic [31:0]    d3_wdat;
   logic [1:0]     d3_flags;
   logic [2:0]     d3_ack_in  = '0;
   logic [95:0]    d3_rdat_in = '0;

   always #5 clk = ~clk;

   wb_bridge_nway u_dut (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
      .wbs_dat_i(wdat), .wbs_adr_i(adr),
      .wbs_ack_o(wbs_ack), .wbs_dat_o(wbs_dat),
      .wbm_stb_o(wbm_stb), .wbm_cyc_o(wbm_cyc), .wbm_we_o(wbm_we), .wbm_sel_o(wbm_sel),
      .wbm_adr_o(wbm_adr), .wbm_dat_o(wbm_dat),
      .wbm_ack_i(wbm_ack), .wbm_dat_i(wbm_rdat),
      .err_clr_i(err_clr), .err_flags_o(err_flags)
   );

   wb_bridge_nway #(.NUM_PORTS(3)) u_dut3 (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
      .wbs_dat_i(wdat), .wbs_adr_i(adr),
      .wbs_ack_o(d3_ack), .wbs_dat_o(d3_dat),
      .wbm_stb_o(d3_stb), .wbm_cyc_o(d3_cyc), .wbm_we_o(d3_we), .wbm_sel_o(d3_sel),
      .wbm_adr_o(d3_adr), .wbm_dat_o(d3_wdat),
      .wbm_ack_i(d3_ack_in), .wbm_dat_i(d3_rdat_in),
      .err_clr_i(err_clr), .err_flags_o(d3_flags)
   );

   // Downstream slaves: the strobed port acks after slv_wait wait states; idle ports may
   // raise stray acks that the bridge must ignore.
   logic [31:0]   port_data [NP];
   int            slv_wait = 0;
   int            slv_cnt  = 0;
   logic [NP-1:0] stray    = '0;

   always @(posedge clk) slv_cnt <= (wbm_stb != '0) ? slv_cnt + 1 : 0;

   always_comb begin
      wbm_ack  = '0;
      wbm_rdat = '0;
      for (int p = 0; p < NP; p++) begin
         wbm_ack[p] = wbm_stb[p] ? (slv_cnt == slv_wait) : stray[p];
         wbm_rdat[32*p +: 32] = port_data[p];
      end
   end

   int         checks = 0;
   int         errors = 0;
   logic [1:0] exp_flags = 2'b00;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ack"}, 32'(wbs_ack), 32'h0);
      check({tag, "_dat"}, wbs_dat, 32'h0);
      check({tag, "_stb"}, 32'(wbm_stb), 32'h0);
      check({tag, "_cyc"}, 32'(wbm_cyc), 32'h0);
      check({tag, "_we"},  32'(wbm_we), 32'h0);
      check({tag, "_sel"}, 32'(wbm_sel), 32'h0);
      check({tag, "_adr"}, 32'(wbm_adr), 32'h0);
      check({tag, "_wdat"}, wbm_dat, 32'h0);
      check({tag, "_flags"}, 32'(err_flags), 32'h0);
   endtask

   task automatic randomize_ports();
      for (int p = 0; p < NP; p++) port_data[p] = $urandom;
   endtask

   // One complete host access; expectations come from the decode/latency rules alone.
   task automatic access(input logic [31:0] a, input logic w, input logic [3:0] s,
                         input logic [31:0] d, input int wait_n, input logic clr_v);
      int          port, lat, exp_lat, stb_cycles, exp_stb;
      logic        mapped, timed_out;
      logic [31:0] exp_dat;
      logic [NP-1:0] exp_oh;
      port      = int'((a >> 20) & 32'h3);
      mapped    = ((a >> 22) == (BASE >> 22)) && (port < NP);
      timed_out = mapped && (wait_n >= T);
      if (!mapped) begin
         exp_lat = 1;      exp_dat = ERR;             exp_stb = 0;
      end else if (timed_out) begin
         exp_lat = T + 1;  exp_dat = ERR;             exp_stb = T;
      end else begin
         exp_lat = wait_n + 2; exp_dat = port_data[port]; exp_stb = wait_n + 1;
      end
      exp_oh = mapped ? NP'(1 << port) : '0;
      if (clr_v)     exp_flags = 2'b00;
      if (!mapped)   exp_flags[0] = 1'b1;
      if (timed_out) exp_flags[1] = 1'b1;

      slv_wait = wait_n;
      stray    = NP'($urandom);
      adr = a; we = w; sel = s; wdat = d; stb = 1'b1; cyc = 1'b1; err_clr = clr_v;
      lat = -1;
      stb_cycles = 0;
      for (int e = 0; e < T + 8 && lat < 0; e++) begin
         tick();
         err_clr = 1'b0;
         if (wbm_stb != '0) begin
            stb_cycles++;
            check("stb_onehot", 32'(wbm_stb), 32'(exp_oh));
            check("cyc_onehot", 32'(wbm_cyc), 32'(exp_oh));
            check("ds_we", 32'(wbm_we), 32'(w));
            check("ds_sel", 32'(wbm_sel), 32'(s));
            check("ds_adr", 32'(wbm_adr), a & 32'h000F_FFFF);
            check("ds_dat", wbm_dat, d);
         end
         if (wbs_ack) lat = e;
      end
      check("ack_latency", lat, exp_lat);
      check("rsp_data", wbs_dat, exp_dat);
      check("stb_cycles", stb_cycles, exp_stb);
      check("err_flags", 32'(err_flags), 32'(exp_flags));
      stb = 1'b0; cyc = 1'b0; stray = '0;
      tick();
      check("ack_single", 32'(wbs_ack), 32'h0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      exp_flags = 2'b00;
   endtask

   initial begin
      rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = '0; wdat = '0; adr = '0;
      err_clr = 1'b0;
      randomize_ports();
      tick();
      tick();
      check_all_zero("reset");
      rst = 1'b0;
      tick();

      // Three-port bridge: index 3 falls outside the port range.
      slv_wait = 0;
      adr = 32'h3030_0000; we = 1'b0; sel = 4'hF; stb = 1'b1; cyc = 1'b1;
      tick();
      check("np3_ack_early", 32'(d3_ack), 32'h0);
      check("np3_stb_e0", 32'(d3_stb), 32'h0);
      check("np3_flag_e0", 32'(d3_flags), 32'h1);
      tick();
      check("np3_ack", 32'(d3_ack), 32'h1);
      check("np3_dat", d3_dat, ERR);
      check("np3_flags", 32'(d3_flags), 32'h1);
      check("np3_stb_e1", 32'(d3_stb), 32'h0);
      stb = 1'b0; cyc = 1'b0; err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check("np3_clr", 32'(d3_flags), 32'h0);
      do_reset();

      port_data[2] = 32'h1234_5678;
      access(32'h3020_0010, 1'b0, 4'hF, 32'h0, 1, 1'b0);
      access(32'h3000_0004, 1'b1, 4'b0011, 32'hA5A5_0F0F, 0, 1'b0);
      access(32'h3100_0000, 1'b0, 4'hF, 32'h0, 0, 1'b0);
      access(32'h3040_0000, 1'b1, 4'hF, 32'h5555_AAAA, 0, 1'b0);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      exp_flags = 2'b00;
      check("clr_flags", 32'(err_flags), 32'h0);

      access(32'h3010_0100, 1'b0, 4'hF, 32'h0, NEVER, 1'b0);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      exp_flags = 2'b00;
      port_data[1] = 32'hCAFE_F00D;
      access(32'h3010_0200, 1'b0, 4'hF, 32'h0, T - 1, 1'b0);
      access(32'h3010_0300, 1'b0, 4'hF, 32'h0, T, 1'b0);

      // Abort: host drops cyc during the third ACTIVE cycle.
      slv_wait = NEVER;
      adr = 32'h3020_0040; we = 1'b0; stb = 1'b1; cyc = 1'b1;
      tick();
      tick();
      tick();
      stb = 1'b0; cyc = 1'b0;
      tick();
      check("abort_stb", 32'(wbm_stb), 32'h0);
      check("abort_cyc", 32'(wbm_cyc), 32'h0);
      for (int i = 0; i < 4; i++) begin
         check("abort_no_ack", 32'(wbs_ack), 32'h0);
         tick();
      end
      check("abort_flags", 32'(err_flags), 32'(exp_flags));

      randomize_ports();
      access(32'h3030_0008, 1'b0, 4'hF, 32'h0, 2, 1'b0);
      access(32'h3010_000C, 1'b0, 4'hF, 32'h0, 0, 1'b0);

      // Reset in the middle of a downstream transfer, with a flag already set.
      access(32'h3200_0000, 1'b0, 4'hF, 32'h0, 0, 1'b0);
      slv_wait = NEVER;
      adr = 32'h3000_0020; we = 1'b1; wdat = 32'h0BAD_F00D; sel = 4'hF; stb = 1'b1; cyc = 1'b1;
      tick();
      tick();
      tick();
      rst = 1'b1;
      tick();
      check_all_zero("midreset");
      rst = 1'b0; stb = 1'b0; cyc = 1'b0;
      exp_flags = 2'b00;
      tick();
      access(32'h3000_0020, 1'b0, 4'hF, 32'h0, 0, 1'b0);

      for (int n = 0; n < 80; n++) begin
         logic [31:0] a;
         int          r, w;
         randomize_ports();
         r = $urandom_range(0, 9);
         if (r < 8) a = BASE | ($urandom_range(0, 3) << 20) | ($urandom & 32'h000F_FFFC);
         else       a = $urandom;
         r = $urandom_range(0, 9);
         if (r < 7)       w = $urandom_range(0, 4);
         else if (r == 7) w = T - 1;
         else if (r == 8) w = T;
         else             w = NEVER;
         access(a, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom, w,
                ($urandom_range(0, 7) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/wb_bridge_nway.md
# wb_bridge_nway

Parametrised N-way Wishbone classic bridge that decodes the Caravel wishbone slave bus into NUM_PORTS address windows, each served by its own downstream master port. It is the successor to the fixed two-way bridge in user_project_wrapper: any port count, a configurable window size, registered forwarding, and two new behaviours. Accesses to unmapped addresses are terminated by the bridge itself, and a downstream port that never acks is timed out, so the CPU never hangs. Both error kinds are recorded in sticky flags.

## Interface
Parameters:
- NUM_PORTS, 4, number of downstream ports (2..16)
- BASE_ADDR, 32'h3000_0000, base of the decoded region; bits below WINDOW_BITS+SEL_BITS must be zero
- WINDOW_BITS, 20, log2 of the window size per port
- DS_ADDR_WIDTH, 20, downstream address width; must be ≤ WINDOW_BITS
- TIMEOUT_CYCLES, 16, downstream wait limit (≥1)
- ERR_DATA, 32'hDEAD_BEEF, read data returned on an error
- SEL_BITS (localparam) = max(1, clog2(NUM_PORTS))

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  synchronous, active-high reset
- wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  upstream request
- wbs_sel_i  in  4  byte select
- wbs_dat_i, wbs_adr_i  in  32 each  write data, address
- wbs_ack_o  out  1  upstream ack
- wbs_dat_o  out  32  upstream read data
- wbm_stb_o, wbm_cyc_o  out  NUM_PORTS  per-port strobe and cycle
- wbm_we_o  out  1  shared write enable
- wbm_sel_o  out  4  shared byte select
- wbm_adr_o  out  DS_ADDR_WIDTH  shared, equal to adr[DS_ADDR_WIDTH-1:0]
- wbm_dat_o  out  32  shared write data
- wbm_ack_i  in  NUM_PORTS  per-port ack
- wbm_dat_i  in  32*NUM_PORTS  port i occupies [32*i +: 32]
- err_clr_i  in  1  clears the sticky flags
- err_flags_o  out  2  sticky {timeout, unmapped}

## Operation
- Decode: idx = adr[WINDOW_BITS +: SEL_BITS].
  - A request is mapped when adr[31:WINDOW_BITS+SEL_BITS] equals the same bits of BASE_ADDR and idx < NUM_PORTS.
  - Otherwise it is unmapped.
- FSM states: IDLE, ACTIVE, RESP.
- IDLE:
  - On stb&cyc, latch adr, dat, sel, we and idx into registers.
  - Mapped: go to ACTIVE with wbm_stb_o[idx] = wbm_cyc_o[idx] = 1 and the timeout counter at 0.
  - Unmapped: go to RESP with error data and set err_flags_o[0].
- ACTIVE:
  - Exactly one bit each of wbm_stb_o and wbm_cyc_o is high; shared outputs hold the latched values.
  - wbm_ack_i[idx] = 1: capture wbm_dat_i[idx], drop stb/cyc, go to RESP.
  - Otherwise, counter == TIMEOUT_CYCLES-1: drop stb/cyc, go to RESP with ERR_DATA and set err_flags_o[1]. Otherwise the counter increments.
  - An ack in the same cycle as the timeout wins; no flag is set.
  - Acks on non-selected ports are ignored.
  - wbs_cyc_i low (abort): drop stb/cyc, return to IDLE, no upstream ack, no flag.
- RESP:
  - wbs_ack_o = 1 for exactly one cycle.
  - wbs_dat_o = captured data, or ERR_DATA on an error. For writes, wbs_dat_o carries the same value and is don't-care to the host.
  - Next state is IDLE.
- wbs_dat_o holds its last value outside RESP.
- err_flags_o: set-on-event, cleared by err_clr_i. If set and clear happen in the same cycle, set wins.
- Reset:
  - Asserting wb_rst_i, including mid-transaction, forces IDLE.
  - All outputs go to 0 on the next edge: wbs_ack_o, wbs_dat_o, all wbm_* outputs, err_flags_o.
  - A downstream transaction in flight is abandoned.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Request sampled at edge 0 (IDLE):
  - Downstream stb/cyc are high after edge 0.
  - A slave acking in the first ACTIVE cycle gives an upstream ack after edge 2.
  - Round trip is 2 + slave wait states.
- Unmapped request: upstream ack after edge 1.
- Timeout: downstream stb is high for exactly TIMEOUT_CYCLES cycles; upstream ack after edge TIMEOUT_CYCLES+1.
- The host drops stb after seeing ack. The bridge is back in IDLE then, so a back-to-back request is accepted with no dead cycle beyond the host's.

## Test plan
Defaults apply unless stated.
- **Reset values:** assert wb_rst_i mid-ACTIVE -> all outputs 0 next cycle, FSM in IDLE, no upstream ack.
- **Mapped read:** read 0x3020_0010, port 2 returns 0x1234_5678 with 1 wait state -> wbm_stb_o = 4'b0100, wbm_adr_o = 20'h00010; wbs_ack_o pulses once, 3 cycles after request; wbs_dat_o = 0x1234_5678.
- **Mapped write:** write 0x3000_0004, sel 4'b0011, data 0xA5A5_0F0F -> port 0 sees we = 1, sel 4'b0011 and that data; exactly one upstream ack; no other port strobed.
- **Unmapped:**
  - NUM_PORTS=3: access 0x3030_0000 -> ack at +1 cycle, data 0xDEAD_BEEF, err_flags_o = 2'b01, no wbm_stb_o bit high.
  - Access 0x3100_0000 -> same response.
  - err_clr_i pulse -> err_flags_o = 0.
- **Timeout:** port 1 never acks -> wbm_stb_o[1] high for 16 cycles, upstream ack at +17 with 0xDEAD_BEEF, err_flags_o = 2'b10. Repeat with the slave acking in cycle 16 -> real data returned, no flag.
- **Abort and back-to-back:**
  - Drop wbs_cyc_i in cycle 3 of ACTIVE -> downstream stb/cyc drop next edge, no ack.
  - Then two back-to-back reads to ports 3 and 1 -> two acks with the correct data, strobes never overlap.
